// File: rtl/i2s_sample_packer_if.sv
// Stream interface carrying packed audio words from the I2S packer to a downstream FIFO.
// The master drives valid/data and the slave returns ready.
interface i2s_sample_packer_if #(
    parameter int DATA_SIZE = 28
) ();
    logic                 source_valid;
    logic [DATA_SIZE-1:0] source_data;
    logic                 source_ready;

    modport master (
        output source_valid,
        output source_data,
        input  source_ready
    );

    modport slave (
        input  source_valid,
        input  source_data,
        output source_ready
    );
endinterface

// File: rtl/i2s_sample_packer.sv
// I2S receiver that captures one sample per channel slot and packs it as {ch, seq, sample}
// into a 2-entry output FIFO, counting words lost to a full FIFO.
module i2s_sample_packer #(
    parameter int SAMPLE_BITS = 24,
    parameter int DATA_SIZE   = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 bclk,
    input  logic                 lrclk,
    input  logic                 sdata,
    i2s_sample_packer_if.master  source,
    output logic [15:0]          overflow_count
);
    localparam int                CNT_W    = $clog2(SAMPLE_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SAMPLE_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LR = 2'd0,
        SKIP    = 2'd1,
        SHIFT   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    logic [1:0]             bclk_sync_r;
    logic [1:0]             lrclk_sync_r;
    logic [1:0]             sdata_sync_r;
    logic                   bclk_prev_r;
    logic                   lr_prev_r;
    logic                   rise_s;
    logic                   lr_change_s;

    state_t                 state_r;
    state_t                 next_state_s;
    logic                   latch_ch_s;
    logic                   clear_cnt_s;
    logic                   shift_s;
    logic                   push_s;

    logic                   ch_r;
    logic [2:0]             seq_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [SAMPLE_BITS-2:0] partial_r;
    logic [DATA_SIZE-1:0]   word_s;

    logic [DATA_SIZE-1:0]   slot0_r;
    logic [DATA_SIZE-1:0]   slot1_r;
    logic [1:0]             count_r;
    logic                   valid_r;
    logic                   pop_s;
    logic                   drop_s;
    logic [15:0]            overflow_r;

    // Two-flop synchronizers plus bclk edge history and the lrclk value seen at the last rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_r  <= 2'b00;
            lrclk_sync_r <= 2'b00;
            sdata_sync_r <= 2'b00;
            bclk_prev_r  <= 1'b0;
            lr_prev_r    <= 1'b0;
        end else begin
            bclk_sync_r  <= {bclk_sync_r[0], bclk};
            lrclk_sync_r <= {lrclk_sync_r[0], lrclk};
            sdata_sync_r <= {sdata_sync_r[0], sdata};
            bclk_prev_r  <= bclk_sync_r[1];
            if (rise_s) begin
                lr_prev_r <= lrclk_sync_r[1];
            end
        end
    end

    assign rise_s      = bclk_sync_r[1] & ~bclk_prev_r;
    assign lr_change_s = rise_s & (lrclk_sync_r[1] != lr_prev_r);

    // Capture state register; dropping enable aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= WAIT_LR;
        end else if (!enable) begin
            state_r <= WAIT_LR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode: a word-select change always restarts the frame, except during the delay bit.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            WAIT_LR: begin
                if (lr_change_s) begin
                    next_state_s = SKIP;
                end else begin
                    next_state_s = WAIT_LR;
                end
            end
            SKIP: begin
                if (rise_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = SKIP;
                end
            end
            SHIFT: begin
                if (lr_change_s) begin
                    next_state_s = SKIP;
                end else if (rise_s && (bit_cnt_r == LAST_BIT)) begin
                    next_state_s = HOLD;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            HOLD: begin
                if (lr_change_s) begin
                    next_state_s = SKIP;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: next_state_s = WAIT_LR;
        endcase
    end

    // Per-state datapath strobes; nothing is captured or pushed while disabled.
    always_comb begin
        latch_ch_s  = 1'b0;
        clear_cnt_s = 1'b0;
        shift_s     = 1'b0;
        push_s      = 1'b0;
        if (enable) begin
            case (state_r)
                WAIT_LR, HOLD: latch_ch_s = lr_change_s;
                SKIP:          clear_cnt_s = rise_s;
                SHIFT: begin
                    if (lr_change_s) begin
                        latch_ch_s = 1'b1;
                    end else if (rise_s) begin
                        shift_s = 1'b1;
                        push_s  = (bit_cnt_r == LAST_BIT);
                    end else begin
                        shift_s = 1'b0;
                    end
                end
                default: latch_ch_s = 1'b0;
            endcase
        end else begin
            latch_ch_s = 1'b0;
        end
    end

    // Channel latch, bit counter, partial sample shifter and sequence counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_r      <= 1'b0;
            seq_r     <= 3'd0;
            bit_cnt_r <= {CNT_W{1'b0}};
            partial_r <= {(SAMPLE_BITS-1){1'b0}};
        end else begin
            if (latch_ch_s) begin
                ch_r <= lrclk_sync_r[1];
            end
            if (clear_cnt_s) begin
                bit_cnt_r <= {CNT_W{1'b0}};
                partial_r <= {(SAMPLE_BITS-1){1'b0}};
            end else if (shift_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_ONE;
                partial_r <= {partial_r[SAMPLE_BITS-3:0], sdata_sync_r[1]};
            end
            if (push_s) begin
                seq_r <= seq_r + 3'd1;
            end
        end
    end

    // The final bit joins the word directly so the push lands one cycle after its rise event.
    assign word_s = {ch_r, seq_r, partial_r, sdata_sync_r[1]};
    assign pop_s  = valid_r & source.source_ready;
    assign drop_s = push_s & ~pop_s & (count_r == 2'd2);

    // Two-entry output FIFO; slot0 is the head and is kept at zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_r <= {DATA_SIZE{1'b0}};
            slot1_r <= {DATA_SIZE{1'b0}};
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        slot0_r <= word_s;
                        count_r <= 2'd1;
                        valid_r <= 1'b1;
                    end
                end
                2'd1: begin
                    case ({push_s, pop_s})
                        2'b11: slot0_r <= word_s;
                        2'b10: begin
                            slot1_r <= word_s;
                            count_r <= 2'd2;
                        end
                        2'b01: begin
                            slot0_r <= {DATA_SIZE{1'b0}};
                            count_r <= 2'd0;
                            valid_r <= 1'b0;
                        end
                        default: count_r <= 2'd1;
                    endcase
                end
                2'd2: begin
                    case ({push_s, pop_s})
                        2'b11: begin
                            slot0_r <= slot1_r;
                            slot1_r <= word_s;
                        end
                        2'b01: begin
                            slot0_r <= slot1_r;
                            slot1_r <= {DATA_SIZE{1'b0}};
                            count_r <= 2'd1;
                        end
                        default: count_r <= 2'd2;
                    endcase
                end
                default: begin
                    slot0_r <= {DATA_SIZE{1'b0}};
                    slot1_r <= {DATA_SIZE{1'b0}};
                    count_r <= 2'd0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of words lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 16'd0;
        end else if (drop_s && (overflow_r != 16'hFFFF)) begin
            overflow_r <= overflow_r + 16'd1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign source.source_valid = valid_r;
    assign source.source_data  = slot0_r;
    assign overflow_count      = overflow_r;
endmodule

// File: tb/tb_i2s_sample_packer.sv
// Directed-plus-random bench for i2s_sample_packer: drives I2S slots bit by bit and compares
// delivered words against a slot-level reference model of the capture rules.
`timescale 1ns/1ps
module tb_i2s_sample_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [15:0] overflow_count;

    i2s_sample_packer_if #(.DATA_SIZE(28)) src_if ();

    i2s_sample_packer #(.SAMPLE_BITS(24), .DATA_SIZE(28)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .sdata          (sdata),
        .source         (src_if),
        .overflow_count (overflow_count)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [27:0] obs_q[$];
    logic [27:0] exp_q[$];
    logic [27:0] held_q[$];
    int          seq_m = 0;
    int          ovf_m = 0;
    bit          last_lr_m = 1'b0;
    bit          ready_low = 1'b0;
    bit          rel_at_push = 1'b0;
    bit          mon_en = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [27:0] prev_data = 28'h0;
    int unsigned valid_hi_cycles = 0;
    int unsigned first_valid_cyc = 0;
    int unsigned last_bit_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: collects transfers, checks zero data when idle and stability under backpressure.
    always @(negedge clk) begin
        if (mon_en) begin
            if (src_if.source_valid === 1'b1) begin
                valid_hi_cycles++;
                if (!prev_valid) first_valid_cyc = cyc;
                if (src_if.source_ready === 1'b1) obs_q.push_back(src_if.source_data);
            end else begin
                chk("idle_data_zero", 32'(src_if.source_data), 32'h0);
            end
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", 32'(src_if.source_valid), 32'h1);
                chk("stall_data", 32'(src_if.source_data), 32'(prev_data));
            end
            prev_valid = (src_if.source_valid === 1'b1);
            prev_ready = (src_if.source_ready === 1'b1);
            prev_data  = src_if.source_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        seq_m     = 0;
        ovf_m     = 0;
        last_lr_m = 1'b0;
        exp_q.delete();
        held_q.delete();
        obs_q.delete();
    endtask

    task automatic release_held();
        foreach (held_q[i]) exp_q.push_back(held_q[i]);
        held_q.delete();
        ready_low = 1'b0;
    endtask

    // Every completed sample consumes a sequence number; with ready held low only two fit.
    task automatic model_push(input bit ch, input logic [23:0] smp);
        logic [27:0] w;
        w = {ch, 3'(seq_m), smp};
        seq_m = (seq_m + 1) % 8;
        if (!ready_low) exp_q.push_back(w);
        else if (held_q.size() < 2) held_q.push_back(w);
        else if (ovf_m < 65535) ovf_m++;
    endtask

    task automatic set_ready(input bit r);
        step();
        src_if.source_ready = r;
        if (r) release_held();
        else ready_low = 1'b1;
    endtask

    // One bclk period of 8 clk cycles; pulse 1 drops enable, pulse 2 asserts reset, both for one clk.
    task automatic send_bit(input bit lr, input bit d, input int pulse, input bit record);
        step();
        bclk = 1'b0; lrclk = lr; sdata = d;
        if (pulse == 1) begin
            step(); enable = 1'b0;
            step(); enable = 1'b1;
        end else if (pulse == 2) begin
            step(); reset = 1'b1;
            step(); reset = 1'b0;
        end else begin
            step(); step();
        end
        step(); step();
        bclk = 1'b1;
        if (record) last_bit_cyc = cyc;
        step(); step();
        if (record && rel_at_push) src_if.source_ready = 1'b1;
        step();
    endtask

    // A slot opens with a word-select change, then one delay bit, then 24 sample bits MSB first.
    task automatic send_slot(input bit ch, input int len, input logic [23:0] smp, input int pulse, input int ppos);
        bit          b[64];
        int          s;
        bit          changed;
        logic [23:0] got;
        for (int i = 0; i < 64; i++) b[i] = 1'($urandom_range(1, 0));
        for (int i = 0; i < 24; i++) b[2+i] = smp[23-i];
        for (int i = 0; i < len; i++) send_bit(ch, b[i], (i == ppos) ? pulse : 0, i == 25);
        s = 0;
        changed = (ch != last_lr_m);
        if (pulse == 2) begin
            model_reset();
            s = ppos;
            changed = (ch != 1'b0);
        end
        if (rel_at_push) begin
            release_held();
            rel_at_push = 1'b0;
        end
        if (changed && (pulse != 1) && ((len - s) >= 26)) begin
            for (int i = 0; i < 24; i++) got[23-i] = b[s+2+i];
            model_push(ch, got);
        end
        last_lr_m = ch;
    endtask

    task automatic check_out(input string tag);
        repeat (12) step();
        for (int i = 0; i < 400; i++) begin
            if (obs_q.size() >= exp_q.size()) break;
            step();
        end
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFFFFFF, 32'(exp_q[i]));
        chk({tag, "_overflow"}, 32'(overflow_count), 32'(ovf_m));
    endtask

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        step(); reset = 1'b1;
        step(); step(); reset = 1'b0;
        model_reset();
        step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
        src_if.source_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_valid", 32'(src_if.source_valid), 32'h0);
        chk("reset_data", 32'(src_if.source_data), 32'h0);
        chk("reset_overflow", 32'(overflow_count), 32'h0);

        // Single left frame with ready high: one word, valid for one cycle, three clks after bclk rise.
        send_slot(1'b1, 4, 24'h0, 0, -1);
        valid_hi_cycles = 0;
        send_slot(1'b0, 32, 24'hA5A5A5, 0, -1);
        check_out("left_frame");
        chk("left_frame_const", 32'(obs_q[0]), 32'h0A5A5A5);
        chk("left_frame_valid_cycles", valid_hi_cycles, 32'd1);
        chk("push_latency", first_valid_cyc - last_bit_cyc, 32'd3);
        clear_q();

        // Stereo pair in 32-bit slots.
        do_reset();
        send_slot(1'b1, 4, 24'h0, 0, -1);
        send_slot(1'b0, 32, 24'h000001, 0, -1);
        send_slot(1'b1, 32, 24'hFFFFFF, 0, -1);
        check_out("stereo");
        chk("stereo_left_const", 32'(obs_q[0]), 32'h0000001);
        chk("stereo_right_const", 32'(obs_q[1]), 32'h9FFFFFF);
        clear_q();

        // Four samples with ready low: two held, two dropped, sequence keeps counting.
        do_reset();
        send_slot(1'b1, 4, 24'h0, 0, -1);
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) send_slot(1'(i % 2 == 1), 32, 24'($urandom), 0, -1);
        repeat (10) step();
        chk("backpressure_overflow", 32'(overflow_count), 32'd2);
        chk("backpressure_valid", 32'(src_if.source_valid), 32'h1);
        set_ready(1'b1);
        send_slot(1'b0, 32, 24'($urandom), 0, -1);
        check_out("backpressure");
        chk("backpressure_seq0", 32'(obs_q[0][26:24]), 32'd0);
        chk("backpressure_seq1", 32'(obs_q[1][26:24]), 32'd1);
        chk("backpressure_seq4", 32'(obs_q[2][26:24]), 32'd4);
        clear_q();

        // Short frame: lrclk toggles after 10 shifted bits, then a full frame on the new channel.
        send_slot(1'b1, 12, 24'($urandom), 0, -1);
        send_slot(1'b0, 32, 24'($urandom), 0, -1);
        check_out("short_frame");
        chk("short_frame_ch", 32'(obs_q[0][27]), 32'd0);
        clear_q();

        // Enable pulse mid-shift with one word queued.
        set_ready(1'b0);
        send_slot(1'b1, 32, 24'($urandom), 0, -1);
        send_slot(1'b0, 32, 24'($urandom), 1, 10);
        send_slot(1'b1, 32, 24'($urandom), 0, -1);
        set_ready(1'b1);
        check_out("enable_abort");
        clear_q();

        // Push and pop in the same cycle, with occupancy 1 and then full.
        set_ready(1'b0);
        send_slot(1'b0, 32, 24'($urandom), 0, -1);
        rel_at_push = 1'b1;
        send_slot(1'b1, 32, 24'($urandom), 0, -1);
        check_out("pushpop_occ1");
        clear_q();
        set_ready(1'b0);
        send_slot(1'b0, 32, 24'($urandom), 0, -1);
        send_slot(1'b1, 32, 24'($urandom), 0, -1);
        rel_at_push = 1'b1;
        send_slot(1'b0, 32, 24'($urandom), 0, -1);
        check_out("pushpop_full");
        clear_q();

        // Reset mid-shift, then a full left frame.
        send_slot(1'b1, 32, 24'($urandom), 2, 12);
        send_slot(1'b0, 32, 24'h123456, 0, -1);
        check_out("reset_mid");
        chk("reset_mid_const", 32'(obs_q[0]), 32'h0123456);
        clear_q();

        // Random slot lengths and samples, alternating channels.
        for (int n = 0; n < 10; n++) begin
            int len;
            len = ($urandom_range(9, 0) < 3) ? int'($urandom_range(25, 3)) : int'($urandom_range(40, 26));
            send_slot(~last_lr_m, len, 24'($urandom), 0, -1);
        end
        check_out("random");
        clear_q();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_sample_packer.md
I2S_SAMPLE_PACKER -- requirements
Module: i2s_sample_packer

Interface
REQ-001 Parameter SAMPLE_BITS, default 24: audio sample width captured per channel.
REQ-002 Parameter DATA_SIZE, default 28: output word width; SHALL equal SAMPLE_BITS+4.
REQ-003 Port clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port enable  input  1  capture enable; low aborts capture, output FIFO still drains.
REQ-006 Port bclk  input  1  I2S bit clock from codec, asynchronous to clk, at most clk/8.
REQ-007 Port lrclk  input  1  I2S word select, asynchronous: 0 = left, 1 = right.
REQ-008 Port sdata  input  1  I2S serial data, MSB first, asynchronous.
REQ-009 Port source_valid  output  1  output word available.
REQ-010 Port source_data  output  DATA_SIZE  packed word {ch[27], seq[26:24], sample[23:0]}.
REQ-011 Port source_ready  input  1  downstream FIFO can accept a word.
REQ-012 Port overflow_count  output  16  number of words dropped because the output buffer was full.

Function
REQ-013 bclk, lrclk and sdata SHALL each pass through a two-flop synchronizer before use.
REQ-014 A bclk rise event SHALL be one clk cycle where the synchronized bclk is 1 and its previous value was 0; sdata and lrclk SHALL be sampled in that cycle.
REQ-015 The FSM SHALL have states WAIT_LR, SKIP, SHIFT and HOLD.
REQ-016 WAIT_LR: on a rise event whose sampled lrclk differs from the lrclk sampled at the previous rise event, go to SKIP and latch ch = new lrclk.
REQ-017 SKIP: the next rise event (the I2S one-bit delay) SHALL be ignored, then go to SHIFT with bit counter = 0.
REQ-018 SHIFT: each rise event SHALL shift sdata into the sample register LSB and increment the counter; on the SAMPLE_BITS-th bit, push the word and go to HOLD.
REQ-019 HOLD: further bits SHALL be ignored until an lrclk change at a rise event; then go to SKIP and latch the new ch.
REQ-020 An lrclk change seen in SHIFT (short frame) SHALL discard the partial sample without a push, latch the new ch, and go to SKIP.
REQ-021 enable low SHALL force WAIT_LR on the next clk and discard any partial sample; FIFO contents and seq SHALL be kept.
REQ-022 The output buffer SHALL be a 2-entry FIFO; source_valid = (occupancy != 0); source_data = head entry, or 0 when empty.
REQ-023 A transfer SHALL occur in a cycle with source_valid and source_ready both high; source_data SHALL stay stable while source_valid=1 and source_ready=0.
REQ-024 Push latency: the word SHALL be in the FIFO, with source_valid=1, in the cycle after the rise event carrying the last sample bit.
REQ-025 seq SHALL be a 3-bit counter that increments on every completed sample, including dropped ones, and wraps 7 -> 0.
REQ-026 Push while full with no pop in the same cycle: the word SHALL be dropped and overflow_count incremented, saturating at 16'hFFFF.
REQ-027 Push and pop in the same cycle while full: both SHALL take effect, with no overflow counted.
REQ-028 Push and pop in the same cycle with occupancy 1: occupancy SHALL remain 1 and the new word becomes the head.

Reset
REQ-029 On reset: the FSM SHALL enter WAIT_LR; source_valid=0, source_data=0, overflow_count=0, seq=0, FIFO empty, bit counter=0, synchronizer and edge history flops=0.
REQ-030 Reset asserted mid-SHIFT SHALL discard the partial sample; the first word after reset SHALL require a fresh lrclk transition.

Verification
REQ-031 Left frame with sample 24'hA5A5A5, source_ready=1 -> one word 28'h0A5A5A5 (ch=0, seq=0), source_valid high for exactly 1 cycle.
REQ-032 Stereo pair L=24'h000001, R=24'hFFFFFF, 32-bit slots -> words 28'h0000001 then 28'h9FFFFFF (ch=1, seq=1); the 8 extra bits per slot are ignored.
REQ-033 source_ready=0 across 4 completed samples -> FIFO holds seq 0 and seq 1, overflow_count=2; after ready rises, words with seq 0 then seq 1 are delivered and the next word carries seq=4.
REQ-034 lrclk toggles after 10 bits of SHIFT -> no word pushed; the following full frame yields a correct word with the new ch.
REQ-035 Reset pulse mid-SHIFT, then a full left frame 24'h123456 -> single word 28'h0123456, overflow_count=0.
REQ-036 enable low for 1 clk mid-SHIFT with one word queued -> the queued word is still delivered, the partial sample is discarded, and capture resumes after the next lrclk edge.
